vend_fsm_param: RTL and testbench

Parametrised successor to the 2-coin vending FSM. It accumulates credit from two coin inputs of configurable value and supports N_PROD products with per-slot prices. It vends on an explicit buy request, dispenses change as one unit pulse per cycle, and supports cancel/refund with overflow rejection. It sits directly behind the top-level ui_in decode and drives uo_out.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_credit_acc.sv | 39 +++
 rtl/vend_fsm_param.sv | 143 ++++++++++++++
 tb/tb_vend_fsm_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending FSM.
//   state_t  : controller state encoding (IDLE / VEND / CHANGE)
//   price_of : per-slot price, base + sel * step
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  // Price of product 'sel' in credit units.
  function automatic int unsigned price_of(input int unsigned sel,
                                           input int unsigned base,
                                           input int unsigned step);
    return base + sel * step;
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Combinational coin accumulator: adds coin A, then coin B, each only if the
// running sum stays within MAX_CREDIT. Any coin not accepted raises o_reject.
//   i_credit    : current registered credit
//   i_coin_a/b  : coin pulses
//   i_accept_en : 0 forces every presented coin to be rejected
//   o_credit    : credit after accepted coins
//   o_reject    : at least one presented coin was not accepted
module vend_credit_acc #(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned COIN_A_VAL = 1,
  parameter int unsigned COIN_B_VAL = 2
) (
  input  logic [CREDIT_W-1:0] i_credit,
  input  logic                i_coin_a,
  input  logic                i_coin_b,
  input  logic                i_accept_en,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_reject
);

  // One extra bit so the sum cannot wrap before the limit compare.
  localparam int unsigned SW = CREDIT_W + 1;

  logic [SW-1:0] w_sum_a, w_cand_a, w_sum_b, w_cand_b;
  logic          w_a_ok, w_b_ok;

  assign w_sum_a  = SW'(i_credit) + SW'(COIN_A_VAL);
  assign w_a_ok   = i_accept_en && i_coin_a && (w_sum_a <= SW'(MAX_CREDIT));
  assign w_cand_a = w_a_ok ? w_sum_a : SW'(i_credit);

  assign w_sum_b  = w_cand_a + SW'(COIN_B_VAL);
  assign w_b_ok   = i_accept_en && i_coin_b && (w_sum_b <= SW'(MAX_CREDIT));
  assign w_cand_b = w_b_ok ? w_sum_b : w_cand_a;

  assign o_credit = CREDIT_W'(w_cand_b);
  assign o_reject = (i_coin_a && !w_a_ok) || (i_coin_b && !w_b_ok);

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: coin credit, priced product vend on buy,
// unit-pulse change dispense and cancel/refund.
//   clk, rst_n   : clock, async active-low reset
//   ena          : block enable, 0 freezes state and silences strobes
//   coin_a/b     : coin pulses
//   sel, buy     : product select and purchase request
//   cancel       : refund request (wins over buy)
//   credit       : current credit
//   prod_valid   : one-cycle vend strobe, prod_id valid with it
//   change_pulse : one unit of change per high cycle
//   coin_reject  : a coin was returned the previous cycle
//   busy         : high in VEND and CHANGE
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned MAX_CREDIT = 15,
  parameter int unsigned COIN_A_VAL = 1,
  parameter int unsigned COIN_B_VAL = 2,
  parameter int unsigned N_PROD     = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PRICE_BASE = 3,
  parameter int unsigned PRICE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                prod_valid,
  output logic [SEL_W-1:0]    prod_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);

  localparam int unsigned PW = CREDIT_W + SEL_W;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt, w_acc_credit;
  logic [SEL_W-1:0]    r_prod_id, w_prod_id_nxt;
  logic                r_prod_valid, r_change_pulse, r_coin_reject, r_busy;
  logic                w_acc_en, w_acc_reject, w_reject_nxt;
  logic                w_sel_ok, w_buy_ok;
  logic [PW-1:0]       w_price_sel, w_price_vend, w_remain;

  // Prices for the requested slot and for the latched product.
  assign w_price_sel  = PW'(price_of(32'(sel), PRICE_BASE, PRICE_STEP));
  assign w_price_vend = PW'(price_of(32'(r_prod_id), PRICE_BASE, PRICE_STEP));
  assign w_sel_ok     = 32'(sel) < N_PROD;
  assign w_buy_ok     = w_sel_ok && (PW'(r_credit) >= w_price_sel);
  assign w_remain     = PW'(r_credit) - w_price_vend;

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT),
    .COIN_A_VAL (COIN_A_VAL),
    .COIN_B_VAL (COIN_B_VAL)
  ) u_acc (
    .i_credit    (r_credit),
    .i_coin_a    (coin_a),
    .i_coin_b    (coin_b),
    .i_accept_en (w_acc_en),
    .o_credit    (w_acc_credit),
    .o_reject    (w_acc_reject)
  );

  // Next-state / next-credit decode.
  // VEND and CHANGE only advance while their strobe is actually showing, so a
  // pause on ena never swallows a vend or a change pulse.
  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_prod_id_nxt = r_prod_id;
    w_acc_en      = 1'b0;
    w_reject_nxt  = 1'b0;
    if (ena) begin
      case (r_state)
        IDLE: begin
          w_acc_en = 1'b1;
          if (cancel) begin
            w_acc_en = 1'b0;
            if (r_credit != '0) w_state_nxt = CHANGE;
          end else if (buy && w_buy_ok) begin
            w_acc_en      = 1'b0;
            w_prod_id_nxt = sel;
            w_state_nxt   = VEND;
          end
          w_credit_nxt = w_acc_credit;
          w_reject_nxt = w_acc_reject;
        end
        VEND: begin
          w_reject_nxt = w_acc_reject;
          if (r_prod_valid) begin
            w_credit_nxt = CREDIT_W'(w_remain);
            w_state_nxt  = (w_remain != '0) ? CHANGE : IDLE;
          end
        end
        CHANGE: begin
          w_reject_nxt = w_acc_reject;
          if (r_change_pulse) begin
            w_credit_nxt = r_credit - CREDIT_W'(1);
            if (r_credit == CREDIT_W'(1)) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, credit and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_prod_id      <= '0;
      r_prod_valid   <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_prod_id      <= w_prod_id_nxt;
      r_coin_reject  <= w_reject_nxt;
      r_prod_valid   <= ena && (w_state_nxt == VEND);
      r_change_pulse <= ena && (w_state_nxt == CHANGE);
      r_busy         <= (w_state_nxt != IDLE);
    end
  end

  assign credit       = r_credit;
  assign prod_valid   = r_prod_valid;
  assign prod_id      = r_prod_id;
  assign change_pulse = r_change_pulse;
  assign coin_reject  = r_coin_reject;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed scenarios followed by random traffic,
// every cycle compared against a schedule-based reference model.
module tb_vend_fsm_param;

  localparam int CREDIT_W   = 4;
  localparam int MAX_CREDIT = 15;
  localparam int COIN_A_VAL = 1;
  localparam int COIN_B_VAL = 2;
  localparam int N_PROD     = 4;
  localparam int SEL_W      = 2;
  localparam int PRICE_BASE = 3;
  localparam int PRICE_STEP = 1;

  logic                clk = 1'b0;
  logic                rst_n, ena, coin_a, coin_b, buy, cancel;
  logic [SEL_W-1:0]    sel;
  logic [CREDIT_W-1:0] credit;
  logic [SEL_W-1:0]    prod_id;
  logic                prod_valid, change_pulse, coin_reject, busy;

  vend_fsm_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .coin_a       (coin_a),
    .coin_b       (coin_b),
    .sel          (sel),
    .buy          (buy),
    .cancel       (cancel),
    .credit       (credit),
    .prod_valid   (prod_valid),
    .prod_id      (prod_id),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Reference model: while a transaction runs, outputs follow a precomputed
  // schedule of per-cycle entries; in between, credit is plain arithmetic.
  typedef struct {
    bit busy;
    bit pv;
    bit cp;
    int credit;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int   m_credit;
  int   m_id;
  bit   m_rej;
  int   checks   = 0;
  int   failures = 0;

  function automatic int price(input int s);
    return PRICE_BASE + s * PRICE_STEP;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur      = '{busy: 1'b0, pv: 1'b0, cp: 1'b0, credit: 0};
    m_credit = 0;
    m_id     = 0;
    m_rej    = 1'b0;
  endtask

  task automatic check_all();
    chk("credit",       int'(credit),       cur.busy ? cur.credit : m_credit);
    chk("prod_valid",   int'(prod_valid),   int'(cur.pv));
    chk("prod_id",      int'(prod_id),      m_id);
    chk("change_pulse", int'(change_pulse), int'(cur.cp));
    chk("coin_reject",  int'(coin_reject),  int'(m_rej));
    chk("busy",         int'(busy),         int'(cur.busy));
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input bit a, input bit b, input bit by,
                            input bit cn, input int s, input bit en);
    int c;
    m_rej = 1'b0;
    if (!en) return;
    if (cur.busy) begin
      m_rej = a | b;
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur      = '{busy: 1'b0, pv: 1'b0, cp: 1'b0, credit: 0};
        m_credit = 0;
      end
    end else if (cn) begin
      m_rej = a | b;
      if (m_credit > 0) begin
        for (int k = m_credit; k >= 1; k--) q.push_back('{1'b1, 1'b0, 1'b1, k});
        m_credit = 0;
        cur = q.pop_front();
      end
    end else if (by && s < N_PROD && m_credit >= price(s)) begin
      m_rej = a | b;
      m_id  = s;
      q.push_back('{1'b1, 1'b1, 1'b0, m_credit});
      for (int k = m_credit - price(s); k >= 1; k--) q.push_back('{1'b1, 1'b0, 1'b1, k});
      m_credit = 0;
      cur = q.pop_front();
    end else begin
      c = m_credit;
      if (a) begin
        if (c + COIN_A_VAL > MAX_CREDIT) m_rej = 1'b1;
        else c += COIN_A_VAL;
      end
      if (b) begin
        if (c + COIN_B_VAL > MAX_CREDIT) m_rej = 1'b1;
        else c += COIN_B_VAL;
      end
      m_credit = c;
    end
  endtask

  task automatic cyc(input bit a, input bit b, input bit by, input bit cn,
                     input int s, input bit en);
    coin_a = a; coin_b = b; buy = by; cancel = cn; sel = SEL_W'(s); ena = en;
    @(posedge clk);
    #1;
    model_edge(a, b, by, cn, s, en);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; coin_a = 1'b0; coin_b = 1'b0;
    buy = 1'b0; cancel = 1'b0; sel = '0;
    model_reset();
    #3;
    check_all();
    #9 rst_n = 1'b1;

    // coin_a + coin_b -> 3, exact-price buy, no change
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    idle(2);

    // 4 credit, buy sel 0 -> one change pulse
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    idle(3);

    // insufficient credit ignored, then vend after topping up
    cyc(0, 1, 0, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1, 1);
    idle(3);

    // credit 5, cancel + buy together -> 5 change pulses, coins rejected
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 1);

    // overflow: 14 then A+B, then B alone
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    idle(16);

    // credit 6, buy sel 0, reset during change
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    idle(2);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    rst_n = 1'b1;
    idle(2);

    // ena = 0 freezes everything, then normal operation resumes
    cyc(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1, 1);
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit a, b, by, cn, en;
      int s;
      a  = ($urandom_range(0, 99) < 35);
      b  = ($urandom_range(0, 99) < 35);
      by = ($urandom_range(0, 99) < 15);
      cn = ($urandom_range(0, 99) < 4);
      s  = int'($urandom_range(0, 3));
      en = cur.busy ? 1'b1 : ($urandom_range(0, 99) >= 10);
      cyc(a, b, by, cn, s, en);
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
